// File: rtl/regbank_arb_pkg.sv
// Shared types and default widths for the register-bank access arbiter.
package regbank_arb_pkg;

    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP   = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    // Counter width able to hold the value 'limit' itself.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/regbank_starve_cnt.sv
// Saturating backdoor-starvation counter; o_hit flags the cycle the count reaches LIMIT.
module regbank_starve_cnt
    import regbank_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int               CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LIM   = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_hit = i_inc && (w_cnt_next == LIM);

endmodule

// File: rtl/regbank_access_arb.sv
// Core/backdoor arbiter for a register bank; core has priority.
// Define BACKDOOR_STARVE_GUARD_EN to enable the starvation counter and forced core stall.
module regbank_access_arb
    import regbank_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              core_rd_we_i,
    input  logic [ADDR_W-1:0] core_rd_addr_i,
    input  logic [DATA_W-1:0] core_rd_data_i,
    input  logic              core_rs_busy_i,
    input  logic [ADDR_W-1:0] core_rs1_addr_i,
    output logic              core_stall_o,
    input  logic              bd_req_valid_i,
    input  logic              bd_req_we_i,
    input  logic [ADDR_W-1:0] bd_req_addr_i,
    input  logic [DATA_W-1:0] bd_req_wdata_i,
    output logic              bd_req_ready_o,
    output logic              bd_rsp_valid_o,
    input  logic              bd_rsp_ready_i,
    output logic [DATA_W-1:0] bd_rsp_rdata_o,
    output logic              rd_we_o,
    output logic [ADDR_W-1:0] rd_address_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] rs1_address_o,
    input  logic [DATA_W-1:0] rs1_data_i
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              w_grant;
    logic              w_force_hit;
    logic [DATA_W-1:0] r_rsp_rdata;
`ifdef BACKDOOR_STARVE_GUARD_EN
    logic              w_stall;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
`ifdef BACKDOOR_STARVE_GUARD_EN
        w_stall      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bd_req_valid_i && (bd_req_we_i ? !core_rd_we_i : !core_rs_busy_i)) begin
                    w_grant      = 1'b1;
                    w_state_next = RSP;
                end else if (w_force_hit) begin
                    w_state_next = FORCE;
                end
            end
            RSP: begin
                if (bd_rsp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
`ifdef BACKDOOR_STARVE_GUARD_EN
            FORCE: begin
                if (bd_req_valid_i) begin
                    w_grant      = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = RSP;
                end else begin
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
        // No grant may leak onto the bank while reset is held.
        if (!rstn) begin
            w_grant = 1'b0;
        end
    end

    // Bank ports follow the core unless the backdoor owns them this cycle.
    always_comb begin
        rd_we_o       = core_rd_we_i & rstn;
        rd_address_o  = core_rd_addr_i;
        rd_data_o     = core_rd_data_i;
        rs1_address_o = core_rs1_addr_i;
`ifdef BACKDOOR_STARVE_GUARD_EN
        if (w_stall) begin
            rd_we_o = 1'b0;
        end
`endif
        if (w_grant && bd_req_we_i) begin
            rd_we_o      = 1'b1;
            rd_address_o = bd_req_addr_i;
            rd_data_o    = bd_req_wdata_i;
        end
        if (w_grant && !bd_req_we_i) begin
            rs1_address_o = bd_req_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_rsp_rdata <= bd_req_we_i ? '0 : rs1_data_i;
            end
        end
    end

`ifdef BACKDOOR_STARVE_GUARD_EN
    regbank_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_inc ((r_state == IDLE) && bd_req_valid_i && !w_grant),
        .i_clr (w_grant || !bd_req_valid_i),
        .o_hit (w_force_hit)
    );
    assign core_stall_o = w_stall;
`else
    assign w_force_hit  = 1'b0;
    assign core_stall_o = 1'b0;
`endif

    assign bd_req_ready_o = w_grant;
    assign bd_rsp_valid_o = (r_state == RSP);
    assign bd_rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_regbank_access_arb.sv
// Randomised + directed bench for regbank_access_arb with a queue-based response scoreboard.
module tb_regbank_access_arb;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          core_rd_we_i, core_rs_busy_i;
    logic [AW-1:0] core_rd_addr_i, core_rs1_addr_i;
    logic [DW-1:0] core_rd_data_i;
    logic          core_stall_o;
    logic          bd_req_valid_i, bd_req_we_i, bd_req_ready_o;
    logic [AW-1:0] bd_req_addr_i;
    logic [DW-1:0] bd_req_wdata_i;
    logic          bd_rsp_valid_o, bd_rsp_ready_i;
    logic [DW-1:0] bd_rsp_rdata_o;
    logic          rd_we_o;
    logic [AW-1:0] rd_address_o, rs1_address_o;
    logic [DW-1:0] rd_data_o, rs1_data_i;

    regbank_access_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .core_rd_we_i(core_rd_we_i), .core_rd_addr_i(core_rd_addr_i),
        .core_rd_data_i(core_rd_data_i), .core_rs_busy_i(core_rs_busy_i),
        .core_rs1_addr_i(core_rs1_addr_i), .core_stall_o(core_stall_o),
        .bd_req_valid_i(bd_req_valid_i), .bd_req_we_i(bd_req_we_i),
        .bd_req_addr_i(bd_req_addr_i), .bd_req_wdata_i(bd_req_wdata_i),
        .bd_req_ready_o(bd_req_ready_o), .bd_rsp_valid_o(bd_rsp_valid_o),
        .bd_rsp_ready_i(bd_rsp_ready_i), .bd_rsp_rdata_o(bd_rsp_rdata_o),
        .rd_we_o(rd_we_o), .rd_address_o(rd_address_o), .rd_data_o(rd_data_o),
        .rs1_address_o(rs1_address_o), .rs1_data_i(rs1_data_i)
    );

    always #5 clk = ~clk;

    // Environment register bank driven by the DUT's bank ports.
    logic [DW-1:0] bank [32];
    assign rs1_data_i = bank[rs1_address_o];
    always @(posedge clk) if (rd_we_o) bank[rd_address_o] <= rd_data_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: abstract arbitration state plus a shadow copy of the bank.
    bit            m_pending, m_force;
    int            m_waited;
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_q [$];

    task automatic model_reset();
        m_pending = 0; m_force = 0; m_waited = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit            exp_ready, exp_stall, exp_we, natural;
        logic [AW-1:0] exp_waddr, exp_rs1;
        logic [DW-1:0] exp_wdata;
        exp_ready = 0;
        exp_stall = 0;
        natural   = bd_req_valid_i && (bd_req_we_i ? !core_rd_we_i : !core_rs_busy_i);
        if (m_pending) exp_ready = 0;
        else if (m_force) begin
            exp_ready = bd_req_valid_i;
            exp_stall = bd_req_valid_i;
        end else exp_ready = natural;

        exp_we    = core_rd_we_i && !exp_stall;
        exp_waddr = core_rd_addr_i;
        exp_wdata = core_rd_data_i;
        exp_rs1   = core_rs1_addr_i;
        if (exp_ready && bd_req_we_i) begin
            exp_we = 1; exp_waddr = bd_req_addr_i; exp_wdata = bd_req_wdata_i;
        end
        if (exp_ready && !bd_req_we_i) exp_rs1 = bd_req_addr_i;

        check("req_ready", bd_req_ready_o, exp_ready);
        check("core_stall", core_stall_o, exp_stall);
        check("rsp_valid", bd_rsp_valid_o, m_pending);
        check("bank_we", rd_we_o, exp_we);
        check("bank_rs1_addr", rs1_address_o, exp_rs1);
        if (exp_we) begin
            check("bank_waddr", rd_address_o, exp_waddr);
            check("bank_wdata", rd_data_o, exp_wdata);
        end

        if (exp_ready) exp_q.push_back(bd_req_we_i ? '0 : ref_mem[bd_req_addr_i]);
        if (exp_we) ref_mem[exp_waddr] = exp_wdata;

        if (m_pending) begin
            if (bd_rsp_ready_i) m_pending = 0;
        end else if (exp_ready) begin
            m_pending = 1; m_force = 0; m_waited = 0;
        end else if (m_force) begin
            m_force = 0; m_waited = 0;
        end else if (bd_req_valid_i) begin
`ifdef BACKDOOR_STARVE_GUARD_EN
            m_waited = (m_waited + 1 > LIM) ? LIM : m_waited + 1;
            if (m_waited == LIM) m_force = 1;
`endif
        end else m_waited = 0;
    endtask

    // Cycle helpers: called at posedge+2 (tick) or posedge+3 (tick_rest); return at next posedge+2.
    task automatic tick_rest();
        #1;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        #1;
        tick_rest();
    endtask

    task automatic set_idle();
        core_rd_we_i = 0; core_rd_addr_i = '0; core_rd_data_i = '0;
        core_rs_busy_i = 0; core_rs1_addr_i = '0;
        bd_req_valid_i = 0; bd_req_we_i = 0; bd_req_addr_i = '0; bd_req_wdata_i = '0;
        bd_rsp_ready_i = 1;
    endtask

    // Monitor: every presented response is compared to the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bd_rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rsp_unexpected: response valid with rdata %h but none expected at %0t",
                             bd_rsp_rdata_o, $time);
                end else begin
                    check("rsp_rdata", bd_rsp_rdata_o, exp_q[0]);
                    if (bd_rsp_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int grant_cyc;
        bit stall_at_grant;
        for (int i = 0; i < 32; i++) begin
            bank[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        set_idle();
        rstn = 0;
        core_rd_we_i = 1;
        bd_req_valid_i = 1; bd_req_we_i = 1;
        @(posedge clk); #2;
        check("reset_ready", bd_req_ready_o, 0);
        check("reset_rsp_valid", bd_rsp_valid_o, 0);
        check("reset_rdata", bd_rsp_rdata_o, 0);
        check("reset_stall", core_stall_o, 0);
        check("reset_bank_we", rd_we_o, 0);
        @(posedge clk); #2;
        rstn = 1;
        set_idle();
        tick();

        // Idle core, backdoor write of 0xDEADBEEF to x5.
        bd_req_valid_i = 1; bd_req_we_i = 1; bd_req_addr_i = 5; bd_req_wdata_i = 32'hDEADBEEF;
        #1;
        check("wr5_bank_we", rd_we_o, 1);
        check("wr5_bank_data", rd_data_o, 32'hDEADBEEF);
        tick_rest();
        set_idle();
        #1;
        check("wr5_rsp_valid", bd_rsp_valid_o, 1);
        check("wr5_rsp_rdata", bd_rsp_rdata_o, 0);
        tick_rest();

        // Core writes x7, then backdoor reads it.
        core_rd_we_i = 1; core_rd_addr_i = 7; core_rd_data_i = 32'h12345678;
        tick();
        set_idle();
        bd_req_valid_i = 1; bd_req_addr_i = 7;
        #1;
        check("rd7_ready", bd_req_ready_o, 1);
        tick_rest();
        set_idle();
        #1;
        check("rd7_rsp_rdata", bd_rsp_rdata_o, 32'h12345678);
        tick_rest();

        // Continuous core writeback starves a pending backdoor write.
        core_rd_we_i = 1; core_rd_addr_i = 3; core_rd_data_i = 32'h0BAD0003;
        bd_req_valid_i = 1; bd_req_we_i = 1; bd_req_addr_i = 9; bd_req_wdata_i = 32'hA5A5A5A5;
        grant_cyc = 0;
        stall_at_grant = 0;
        for (int c = 1; c <= 40 && grant_cyc == 0; c++) begin
            #1;
            if (bd_req_ready_o) begin
                grant_cyc = c;
                stall_at_grant = core_stall_o;
            end
            tick_rest();
        end
`ifdef BACKDOOR_STARVE_GUARD_EN
        check("starve_grant_cycle", grant_cyc, 16);
        check("starve_stall_at_grant", stall_at_grant, 1);
`else
        check("starve_grant_cycle", grant_cyc, 0);
`endif
        set_idle();
        tick();
        tick();

        // Response held off for four cycles while another request waits.
        bd_req_valid_i = 1; bd_req_addr_i = 7; bd_rsp_ready_i = 0;
        tick();
        bd_req_we_i = 1; bd_req_addr_i = 2; bd_req_wdata_i = 32'h22;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("hold_rsp_valid", bd_rsp_valid_o, 1);
            check("hold_rsp_rdata", bd_rsp_rdata_o, 32'h12345678);
            check("hold_no_grant", bd_req_ready_o, 0);
            tick_rest();
        end
        bd_rsp_ready_i = 1;
        bd_req_valid_i = 0;
        tick();

        // Reset while a response is outstanding.
        bd_req_valid_i = 1; bd_req_we_i = 0; bd_req_addr_i = 5; bd_rsp_ready_i = 0;
        tick();
        set_idle();
        bd_rsp_ready_i = 0;
        #1;
        check("pre_reset_rsp_valid", bd_rsp_valid_o, 1);
        rstn = 0;
        #1;
        check("reset_drops_rsp", bd_rsp_valid_o, 0);
        model_reset();
        @(posedge clk); #2;
        rstn = 1;
        set_idle();
        bd_req_valid_i = 1; bd_req_we_i = 1; bd_req_addr_i = 1; bd_req_wdata_i = 32'h11;
        #1;
        check("post_reset_grant", bd_req_ready_o, 1);
        tick_rest();

        // Randomised traffic against the model and scoreboard.
        for (int c = 0; c < 800; c++) begin
            core_rd_we_i    = ($urandom_range(0, 1) == 1);
            core_rd_addr_i  = AW'($urandom_range(0, 31));
            core_rd_data_i  = $urandom;
            core_rs_busy_i  = ($urandom_range(0, 1) == 1);
            core_rs1_addr_i = AW'($urandom_range(0, 31));
            bd_req_valid_i  = ($urandom_range(0, 9) < 6);
            bd_req_we_i     = ($urandom_range(0, 1) == 1);
            bd_req_addr_i   = AW'($urandom_range(0, 31));
            bd_req_wdata_i  = $urandom;
            bd_rsp_ready_i  = ($urandom_range(0, 9) < 6);
            tick();
        end

        set_idle();
        for (int c = 0; c < 4; c++) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
